// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded fields and operands, bypasses same-cycle
// writeback data, inserts load-use bubbles, honours stall/flush, counts bubbles.
module id_ex_stage #(
  parameter int              DATA_W = 32,
  parameter int              REG_AW = 6,
  parameter int              OP_W   = 4,
  parameter logic [OP_W-1:0] LD_OP  = 4'b1110,
  parameter int              CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [OP_W-1:0]   in_op,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [REG_AW-1:0] in_rs,
  input  logic [REG_AW-1:0] in_rt,
  input  logic              in_use_rs,
  input  logic              in_use_rt,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              wb_wrt,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              stall,
  input  logic              flush,
  output logic              upstream_hold,
  output logic              ex_valid,
  output logic [OP_W-1:0]   ex_op,
  output logic [REG_AW-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic              ex_use_rt;
  logic              load_use;
  logic              hold_a_hit;
  logic              hold_b_hit;
  logic [DATA_W-1:0] byp_a;
  logic [DATA_W-1:0] byp_b;

  always_comb begin
    load_use = in_valid & ex_valid & (ex_op == LD_OP) &
               ((in_use_rs & (in_rs == ex_rd)) | (in_use_rt & (in_rt == ex_rd)));
    upstream_hold = rst_n & ~flush & (stall | load_use);
    byp_a = (wb_wrt && (wb_rd == in_rs)) ? wb_data : rs_val;
    byp_b = (wb_wrt && (wb_rd == in_rt)) ? wb_data : rt_val;
    // A held instruction must still see results that retire while it waits.
    hold_a_hit = wb_wrt & ex_valid & (wb_rd == ex_rs);
    hold_b_hit = wb_wrt & ex_valid & ex_use_rt & (wb_rd == ex_rt);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_op      <= '0;
      ex_rd      <= '0;
      ex_a       <= '0;
      ex_b       <= '0;
      ex_imm     <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_use_rt  <= 1'b0;
      bubble_cnt <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (stall) begin
      if (hold_a_hit) ex_a <= wb_data;
      if (hold_b_hit) ex_b <= wb_data;
    end else if (load_use) begin
      ex_valid <= 1'b0;
      if (bubble_cnt != {CNT_W{1'b1}})
        bubble_cnt <= bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      ex_valid  <= in_valid;
      ex_op     <= in_op;
      ex_rd     <= in_rd;
      ex_imm    <= in_imm;
      ex_a      <= byp_a;
      ex_b      <= byp_b;
      ex_rs     <= in_rs;
      ex_rt     <= in_rt;
      ex_use_rt <= in_use_rt;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a 16-bit-counter instance plus a 2-bit-counter
// instance driven in parallel to exercise bubble-count saturation.
module tb_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [3:0]  in_op;
  logic [5:0]  in_rd, in_rs, in_rt;
  logic        in_use_rs, in_use_rt;
  logic [31:0] rs_val, rt_val, in_imm;
  logic        wb_wrt;
  logic [5:0]  wb_rd;
  logic [31:0] wb_data;
  logic        stall, flush;

  logic        upstream_hold, ex_valid;
  logic [3:0]  ex_op;
  logic [5:0]  ex_rd;
  logic [31:0] ex_a, ex_b, ex_imm;
  logic [15:0] bubble_cnt;

  logic        s_hold, s_valid;
  logic [3:0]  s_op;
  logic [5:0]  s_rd;
  logic [31:0] s_a, s_b, s_imm;
  logic [1:0]  s_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  id_ex_stage u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_op(in_op), .in_rd(in_rd),
    .in_rs(in_rs), .in_rt(in_rt), .in_use_rs(in_use_rs), .in_use_rt(in_use_rt),
    .rs_val(rs_val), .rt_val(rt_val), .in_imm(in_imm), .wb_wrt(wb_wrt),
    .wb_rd(wb_rd), .wb_data(wb_data), .stall(stall), .flush(flush),
    .upstream_hold(upstream_hold), .ex_valid(ex_valid), .ex_op(ex_op),
    .ex_rd(ex_rd), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
    .bubble_cnt(bubble_cnt)
  );

  id_ex_stage #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_op(in_op), .in_rd(in_rd),
    .in_rs(in_rs), .in_rt(in_rt), .in_use_rs(in_use_rs), .in_use_rt(in_use_rt),
    .rs_val(rs_val), .rt_val(rt_val), .in_imm(in_imm), .wb_wrt(wb_wrt),
    .wb_rd(wb_rd), .wb_data(wb_data), .stall(stall), .flush(flush),
    .upstream_hold(s_hold), .ex_valid(s_valid), .ex_op(s_op),
    .ex_rd(s_rd), .ex_a(s_a), .ex_b(s_b), .ex_imm(s_imm),
    .bubble_cnt(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [5:0] rd, input logic [5:0] rs,
                       input logic [5:0] rt, input logic urs, input logic urt,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    in_valid  = 1'b1;
    in_op     = op;
    in_rd     = rd;
    in_rs     = rs;
    in_rt     = rt;
    in_use_rs = urs;
    in_use_rt = urt;
    rs_val    = a;
    rt_val    = b;
    in_imm    = imm;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b1; flush = 1'b0;
    wb_wrt = 1'b0; wb_rd = '0; wb_data = '0;
    drive(4'h4, 6'd1, 6'd2, 6'd3, 1'b1, 1'b1, 32'hDEAD, 32'hBEEF, 32'h1);

    // reset with live inputs and a pending stall
    tick(); tick();
    chk("rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_op", {28'd0, ex_op}, 32'd0);
    chk("rst_rd", {26'd0, ex_rd}, 32'd0);
    chk("rst_a", ex_a, 32'd0);
    chk("rst_b", ex_b, 32'd0);
    chk("rst_imm", ex_imm, 32'd0);
    chk("rst_cnt", {16'd0, bubble_cnt}, 32'd0);
    chk("rst_hold", {31'd0, upstream_hold}, 32'd0);

    // plain load
    rst_n = 1'b1; stall = 1'b0;
    drive(4'h4, 6'd1, 6'd2, 6'd3, 1'b1, 1'b1, 32'd5, 32'd7, 32'd9);
    #1 chk("load_hold", {31'd0, upstream_hold}, 32'd0);
    tick();
    chk("load_valid", {31'd0, ex_valid}, 32'd1);
    chk("load_op", {28'd0, ex_op}, 32'h4);
    chk("load_rd", {26'd0, ex_rd}, 32'd1);
    chk("load_a", ex_a, 32'd5);
    chk("load_b", ex_b, 32'd7);
    chk("load_imm", ex_imm, 32'd9);

    // writeback bypass onto rs only
    wb_wrt = 1'b1; wb_rd = 6'd2; wb_data = 32'd99;
    tick();
    chk("byp_a", ex_a, 32'd99);
    chk("byp_b", ex_b, 32'd7);

    // register 0 is ordinary: bypass applies to both operands
    drive(4'h5, 6'd0, 6'd0, 6'd0, 1'b1, 1'b1, 32'd1, 32'd2, 32'd0);
    wb_rd = 6'd0; wb_data = 32'd123;
    tick();
    chk("r0_a", ex_a, 32'd123);
    chk("r0_b", ex_b, 32'd123);

    // load-use hazard
    wb_wrt = 1'b0;
    drive(4'hE, 6'd4, 6'd1, 6'd1, 1'b1, 1'b1, 32'd0, 32'd0, 32'd0);
    tick();
    chk("ld_op", {28'd0, ex_op}, 32'hE);
    drive(4'h4, 6'd5, 6'd4, 6'd7, 1'b1, 1'b0, 32'd11, 32'd22, 32'd3);
    #1 chk("lu_hold", {31'd0, upstream_hold}, 32'd1);
    tick();
    chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
    chk("lu_cnt", {16'd0, bubble_cnt}, 32'd1);
    chk("lu_hold_clr", {31'd0, upstream_hold}, 32'd0);
    tick();
    chk("lu_valid", {31'd0, ex_valid}, 32'd1);
    chk("lu_rd", {26'd0, ex_rd}, 32'd5);
    chk("lu_a", ex_a, 32'd11);
    chk("lu_cnt2", {16'd0, bubble_cnt}, 32'd1);

    // stall with writeback refresh of the held rs operand
    drive(4'h3, 6'd8, 6'd6, 6'd9, 1'b1, 1'b1, 32'd60, 32'd90, 32'd15);
    tick();
    chk("st_a0", ex_a, 32'd60);
    stall = 1'b1;
    drive(4'h2, 6'd1, 6'd1, 6'd1, 1'b0, 1'b0, 32'd1, 32'd1, 32'd0);
    #1 chk("st_hold", {31'd0, upstream_hold}, 32'd1);
    tick();
    chk("st_a1", ex_a, 32'd60);
    wb_wrt = 1'b1; wb_rd = 6'd6; wb_data = 32'd42;
    tick();
    wb_wrt = 1'b0;
    chk("st_a2", ex_a, 32'd42);
    chk("st_b2", ex_b, 32'd90);
    tick();
    chk("st_a3", ex_a, 32'd42);
    chk("st_b3", ex_b, 32'd90);
    chk("st_op", {28'd0, ex_op}, 32'h3);
    chk("st_rd", {26'd0, ex_rd}, 32'd8);
    chk("st_imm", ex_imm, 32'd15);
    chk("st_valid", {31'd0, ex_valid}, 32'd1);

    // flush overrides stall
    flush = 1'b1;
    #1 chk("fl_hold", {31'd0, upstream_hold}, 32'd0);
    tick();
    chk("fl_valid", {31'd0, ex_valid}, 32'd0);
    flush = 1'b0; stall = 1'b0;

    // counter saturation: a self-dependent load gives a bubble every other cycle
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    drive(4'hE, 6'd4, 6'd4, 6'd0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0);
    tick();
    for (int i = 0; i < 6; i++) tick();
    chk("sat_cnt3", {30'd0, s_cnt}, 32'd3);
    chk("wide_cnt3", {16'd0, bubble_cnt}, 32'd3);
    for (int i = 0; i < 4; i++) tick();
    chk("sat_cnt5", {30'd0, s_cnt}, 32'd3);
    chk("wide_cnt5", {16'd0, bubble_cnt}, 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
